// File: rtl/ternary_pc_stack_pkg.sv
// Shared trit encodings, op codes and trit conversion helpers for the ternary PC.
package ternary_pc_stack_pkg;

    localparam logic [1:0] T_NEG  = 2'b11;
    localparam logic [1:0] T_ZERO = 2'b00;
    localparam logic [1:0] T_POS  = 2'b01;
    localparam logic [1:0] T_BAD  = 2'b10;

    localparam int unsigned DEF_WORD_SIZE     = 9;
    localparam int unsigned DEF_MEM_ADDR_SIZE = 3;

    typedef enum logic [2:0] {
        OP_HOLD = 3'd0,
        OP_INC  = 3'd1,
        OP_REL  = 3'd2,
        OP_JMP  = 3'd3,
        OP_CALL = 3'd4,
        OP_RET  = 3'd5
    } op_t;

    // The illegal code decodes as 0 so arithmetic never propagates it.
    function automatic int trit_val(input logic [1:0] t);
        case (t)
            T_POS:   return 1;
            T_NEG:   return -1;
            default: return 0;
        endcase
    endfunction

    function automatic logic [1:0] trit_enc(input int v);
        if (v > 0)
            return T_POS;
        else if (v < 0)
            return T_NEG;
        else
            return T_ZERO;
    endfunction

endpackage

// File: rtl/ternary_pc_stack_adder.sv
// Combinational N-trit balanced-ternary ripple adder with carry-in and carry-out trits.
module ternary_adder
    import ternary_pc_stack_pkg::*;
#(
    parameter int unsigned N = 3
) (
    input  logic [2*N-1:0] a,
    input  logic [2*N-1:0] b,
    input  logic [1:0]     cin,
    output logic [2*N-1:0] sum,
    output logic [1:0]     cout
);

    always_comb begin
        int         s;
        logic [1:0] c;
        sum = '0;
        c   = cin;
        s   = 0;
        for (int unsigned i = 0; i < N; i++) begin
            s = trit_val(a[2*i +: 2]) + trit_val(b[2*i +: 2]) + trit_val(c);
            if (s > 1) begin
                sum[2*i +: 2] = trit_enc(s - 3);
                c             = T_POS;
            end else if (s < -1) begin
                sum[2*i +: 2] = trit_enc(s + 3);
                c             = T_NEG;
            end else begin
                sum[2*i +: 2] = trit_enc(s);
                c             = T_ZERO;
            end
        end
        cout = c;
    end

endmodule

// File: rtl/ternary_pc_stack.sv
// Balanced-ternary program counter with a LIFO return-address stack.
module ternary_pc_stack
    import ternary_pc_stack_pkg::*;
#(
    parameter int unsigned WORD_SIZE     = DEF_WORD_SIZE,
    parameter int unsigned MEM_ADDR_SIZE = DEF_MEM_ADDR_SIZE,
    parameter int unsigned STACK_DEPTH   = 4
) (
    input  logic                               clock,
    input  logic                               reset_enable,
    input  logic [2:0]                         op,
    input  logic [2*WORD_SIZE-1:0]             value,
    output logic [2*MEM_ADDR_SIZE-1:0]         out,
    output logic [$clog2(STACK_DEPTH+1)-1:0]   stack_count,
    output logic                               stack_full,
    output logic                               stack_empty,
    output logic                               wrap,
    output logic                               illegal_trit,
    output logic                               stack_error
);

    localparam int unsigned N  = MEM_ADDR_SIZE;
    localparam int unsigned AW = 2 * N;
    localparam int unsigned CW = $clog2(STACK_DEPTH + 1);

    logic [AW-1:0] stack [STACK_DEPTH];
    logic [AW-1:0] opnd;
    logic          opnd_bad;
    logic [AW-1:0] rel_sum;
    logic [AW-1:0] inc_sum;
    logic [1:0]    rel_carry;
    logic [1:0]    inc_carry;
    logic [AW-1:0] stack_top;

    // Only the low N trits are used; the illegal code is replaced by 0 and flagged.
    always_comb begin
        opnd     = '0;
        opnd_bad = 1'b0;
        for (int unsigned i = 0; i < N; i++) begin
            if (value[2*i +: 2] == T_BAD)
                opnd_bad = 1'b1;
            else
                opnd[2*i +: 2] = value[2*i +: 2];
        end
    end

    ternary_adder #(.N(N)) u_rel_add (
        .a    (out),
        .b    (opnd),
        .cin  (T_ZERO),
        .sum  (rel_sum),
        .cout (rel_carry)
    );

    ternary_adder #(.N(N)) u_inc_add (
        .a    (out),
        .b    ('0),
        .cin  (T_POS),
        .sum  (inc_sum),
        .cout (inc_carry)
    );

    always_comb begin
        stack_top = '0;
        for (int unsigned i = 0; i < STACK_DEPTH; i++) begin
            if (CW'(i + 1) == stack_count)
                stack_top = stack[i];
        end
    end

    assign stack_full  = (stack_count == CW'(STACK_DEPTH));
    assign stack_empty = (stack_count == '0);

    always_ff @(posedge clock or posedge reset_enable) begin
        if (reset_enable) begin
            out          <= '0;
            stack_count  <= '0;
            wrap         <= 1'b0;
            illegal_trit <= 1'b0;
            stack_error  <= 1'b0;
            for (int unsigned i = 0; i < STACK_DEPTH; i++)
                stack[i] <= '0;
        end else begin
            wrap         <= 1'b0;
            illegal_trit <= 1'b0;
            case (op)
                OP_INC: begin
                    out  <= inc_sum;
                    wrap <= (inc_carry != T_ZERO);
                end
                OP_REL: begin
                    out          <= rel_sum;
                    wrap         <= (rel_carry != T_ZERO);
                    illegal_trit <= opnd_bad;
                end
                OP_JMP: begin
                    out          <= opnd;
                    illegal_trit <= opnd_bad;
                end
                OP_CALL: begin
                    illegal_trit <= opnd_bad;
                    if (stack_full) begin
                        stack_error <= 1'b1;
                    end else begin
                        for (int unsigned i = 0; i < STACK_DEPTH; i++) begin
                            if (CW'(i) == stack_count)
                                stack[i] <= inc_sum;
                        end
                        stack_count <= stack_count + CW'(1);
                        out         <= opnd;
                        wrap        <= (inc_carry != T_ZERO);
                    end
                end
                OP_RET: begin
                    if (stack_empty) begin
                        stack_error <= 1'b1;
                    end else begin
                        out         <= stack_top;
                        stack_count <= stack_count - CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ternary_pc_stack.sv
// Scoreboard bench: directed ops push expected state; a monitor pops and compares after each sample point.
module tb_ternary_pc_stack;

    localparam logic [2:0] HOLD = 3'd0, INC = 3'd1, REL = 3'd2, JMP = 3'd3, CALL = 3'd4, RET = 3'd5;

    logic        clock = 1'b0;
    logic        reset_enable;
    logic [2:0]  op;
    logic [17:0] value;
    logic [5:0]  out;
    logic [2:0]  stack_count;
    logic        stack_full, stack_empty, wrap, illegal_trit, stack_error;

    ternary_pc_stack #(.WORD_SIZE(9), .MEM_ADDR_SIZE(3), .STACK_DEPTH(4)) dut (
        .clock        (clock),
        .reset_enable (reset_enable),
        .op           (op),
        .value        (value),
        .out          (out),
        .stack_count  (stack_count),
        .stack_full   (stack_full),
        .stack_empty  (stack_empty),
        .wrap         (wrap),
        .illegal_trit (illegal_trit),
        .stack_error  (stack_error)
    );

    always #5 clock = ~clock;

    typedef struct {
        string name;
        int    pc;
        int    cnt;
        logic  wr;
        logic  ill;
        logic  err;
    } exp_t;

    exp_t q[$];
    event chk_ev;
    int   n_vec = 0;
    int   n_bad = 0;

    function automatic logic [17:0] tenc(input int v);
        logic [17:0] r;
        int x, m;
        r = '0;
        x = v;
        for (int i = 0; i < 9; i++) begin
            m = ((x % 3) + 3) % 3;
            if (m == 1) begin
                r[2*i +: 2] = 2'b01;
                x = (x - 1) / 3;
            end else if (m == 2) begin
                r[2*i +: 2] = 2'b11;
                x = (x + 1) / 3;
            end else begin
                x = x / 3;
            end
        end
        return r;
    endfunction

    function automatic int tdec(input logic [5:0] x);
        int acc, p;
        acc = 0;
        p = 1;
        for (int i = 0; i < 3; i++) begin
            if (x[2*i +: 2] == 2'b01) acc += p;
            else if (x[2*i +: 2] == 2'b11) acc -= p;
            else if (x[2*i +: 2] == 2'b10) acc += 1000;
            p *= 3;
        end
        return acc;
    endfunction

    task automatic cmp(input string nm, input string f, input int got, input int want);
        if (got != want) begin
            n_bad++;
            $display("FAIL %s %s: got %0d want %0d", nm, f, got, want);
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(posedge clock or chk_ev);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                n_vec++;
                cmp(e.name, "out", tdec(out), e.pc);
                cmp(e.name, "stack_count", int'(stack_count), e.cnt);
                cmp(e.name, "stack_full", int'(stack_full), int'(e.cnt == 4));
                cmp(e.name, "stack_empty", int'(stack_empty), int'(e.cnt == 0));
                cmp(e.name, "wrap", int'(wrap), int'(e.wr));
                cmp(e.name, "illegal_trit", int'(illegal_trit), int'(e.ill));
                cmp(e.name, "stack_error", int'(stack_error), int'(e.err));
            end
        end
    end

    task automatic expect_now(input string nm, input int pc, input int cnt, input logic wr, input logic ill, input logic err);
        exp_t e;
        e = '{nm, pc, cnt, wr, ill, err};
        q.push_back(e);
    endtask

    task automatic step(input string nm, input logic [2:0] o, input logic [17:0] v,
                        input int pc, input int cnt, input logic wr, input logic ill, input logic err);
        @(negedge clock);
        op    = o;
        value = v;
        expect_now(nm, pc, cnt, wr, ill, err);
    endtask

    task automatic do_reset(input string nm);
        @(negedge clock);
        reset_enable = 1'b1;
        op    = HOLD;
        value = '0;
        #1;
        expect_now(nm, 0, 0, 1'b0, 1'b0, 1'b0);
        -> chk_ev;
        @(negedge clock);
        reset_enable = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want completion");
        n_bad++;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $fatal(1, "watchdog");
    end

    initial begin
        reset_enable = 1'b1;
        op    = HOLD;
        value = '0;
        #2;
        expect_now("reset0", 0, 0, 1'b0, 1'b0, 1'b0);
        -> chk_ev;
        @(negedge clock);
        reset_enable = 1'b0;

        step("inc1",  INC, '0,        1, 0, 1'b0, 1'b0, 1'b0);
        step("inc2",  INC, '0,        2, 0, 1'b0, 1'b0, 1'b0);
        step("rel+3", REL, tenc(3),   5, 0, 1'b0, 1'b0, 1'b0);
        step("rel-1", REL, tenc(-1),  4, 0, 1'b0, 1'b0, 1'b0);

        do_reset("reset1");
        step("rel13a",   REL,  tenc(13),  13, 0, 1'b0, 1'b0, 1'b0);
        step("rel13b",   REL,  tenc(13),  -1, 0, 1'b1, 1'b0, 1'b0);
        step("jmp13",    JMP,  tenc(13),  13, 0, 1'b0, 1'b0, 1'b0);
        step("incwrap",  INC,  '0,       -13, 0, 1'b1, 1'b0, 1'b0);
        step("hold",     HOLD, '0,       -13, 0, 1'b0, 1'b0, 1'b0);
        step("decwrap",  REL,  tenc(-1),  13, 0, 1'b1, 1'b0, 1'b0);
        step("op7hold",  3'd7, tenc(4),   13, 0, 1'b0, 1'b0, 1'b0);
        step("trunc27",  REL,  tenc(27),  13, 0, 1'b0, 1'b0, 1'b0);
        step("illegal",  REL,  18'h00006, -11, 0, 1'b1, 1'b1, 1'b0);
        step("illclr",   HOLD, '0,       -11, 0, 1'b0, 1'b0, 1'b0);

        do_reset("reset2");
        step("jmp5",   JMP,  tenc(5),   5, 0, 1'b0, 1'b0, 1'b0);
        step("call10", CALL, tenc(10), 10, 1, 1'b0, 1'b0, 1'b0);
        step("call-4", CALL, tenc(-4), -4, 2, 1'b0, 1'b0, 1'b0);
        step("ret1",   RET,  '0,       11, 1, 1'b0, 1'b0, 1'b0);
        step("ret2",   RET,  '0,        6, 0, 1'b0, 1'b0, 1'b0);
        step("ret3",   RET,  '0,        6, 0, 1'b0, 1'b0, 1'b1);
        step("errsty", INC,  '0,        7, 0, 1'b0, 1'b0, 1'b1);

        do_reset("reset3");
        step("fill1", CALL, tenc(1), 1, 1, 1'b0, 1'b0, 1'b0);
        step("fill2", CALL, tenc(2), 2, 2, 1'b0, 1'b0, 1'b0);
        step("fill3", CALL, tenc(3), 3, 3, 1'b0, 1'b0, 1'b0);
        step("fill4", CALL, tenc(4), 4, 4, 1'b0, 1'b0, 1'b0);
        step("over",  CALL, tenc(9), 4, 4, 1'b0, 1'b0, 1'b1);
        step("popf",  RET,  '0,      4, 3, 1'b0, 1'b0, 1'b1);
        step("popf2", RET,  '0,      3, 2, 1'b0, 1'b0, 1'b1);

        do_reset("reset4");
        step("jmp13b",   JMP,  tenc(13), 13, 0, 1'b0, 1'b0, 1'b0);
        step("callwrap", CALL, tenc(2),   2, 1, 1'b1, 1'b0, 1'b0);
        step("retwrap",  RET,  '0,      -13, 0, 1'b0, 1'b0, 1'b0);

        do_reset("reset5");
        step("call5", CALL, tenc(5), 5, 1, 1'b0, 1'b0, 1'b0);
        @(negedge clock);
        op    = CALL;
        value = tenc(7);
        #2;
        reset_enable = 1'b1;
        #1;
        expect_now("asyncrst", 0, 0, 1'b0, 1'b0, 1'b0);
        -> chk_ev;
        @(negedge clock);
        reset_enable = 1'b0;
        op    = HOLD;
        value = '0;
        step("nopush", HOLD, '0, 0, 0, 1'b0, 1'b0, 1'b0);

        repeat (3) @(negedge clock);
        if (q.size() != 0) begin
            $display("FAIL drain: got %0d pending want 0", q.size());
            n_bad++;
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
